// File: rtl/bit_serial_adder.sv
// LSB-first serial adder: one fullAdder cell, a carry flop, and operand/result
// shift registers, controlled by an IDLE/RUN/DONE handshake.

module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum_c,
  output logic cout_c
);
  assign sum_c  = a ^ b ^ cin;
  assign cout_c = (a & b) | (cin & (a ^ b));
endmodule

module bit_serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;

  fullAdder u_fa (
    .a      (op_a[0]),
    .b      (op_b[0]),
    .cin    (carry),
    .sum_c  (fa_sum),
    .cout_c (fa_cout)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign COUT     = carry;

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (START) state_next = S_RUN;
      S_RUN:   if (last_bit) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register; BUSY/DONE are registered decodes of the next state
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      state <= state_next;
      BUSY  <= (state_next == S_RUN);
      DONE  <= (state_next == S_DONE);
    end
  end

  // Datapath: load on accept, then one bit per RUN edge with sum entering at the MSB
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_a  <= '0;
      op_b  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      SUM   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            op_a  <= A;
            op_b  <= B;
            carry <= CIN;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          SUM   <= (SUM >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
          carry <= fa_cout;
          cnt   <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder: an 8-bit instance for directed/random
// cases and a 3-bit instance swept exhaustively with START held high.

module tb_bit_serial_adder;

  logic       clk = 1'b0;
  logic       rst8, start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       rst3, start3, cin3, busy3, done3, cout3;
  logic [2:0] a3, b3, sum3;

  int total = 0;
  int bad   = 0;

  logic [8:0] sb8[$];
  logic [3:0] sb3[$];

  always #5 clk = ~clk;

  bit_serial_adder #(.WIDTH(8)) u8 (
    .CLK(clk), .RST(rst8), .START(start8), .A(a8), .B(b8), .CIN(cin8),
    .BUSY(busy8), .DONE(done8), .SUM(sum8), .COUT(cout8)
  );

  bit_serial_adder #(.WIDTH(3)) u3 (
    .CLK(clk), .RST(rst3), .START(start3), .A(a3), .B(b3), .CIN(cin3),
    .BUSY(busy3), .DONE(done3), .SUM(sum3), .COUT(cout3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: pop the scoreboard whenever a DONE pulse is presented
  always @(negedge clk) begin
    if (done8) begin
      if (sb8.size() == 0) begin
        total++;
        bad++;
        $display("FAIL u8_unexpected_done: got DONE=1, expected no pending result (t=%0t)", $time);
      end else begin
        check("u8_result", 32'({cout8, sum8}), 32'(sb8.pop_front()));
      end
    end
    if (done3) begin
      if (sb3.size() == 0) begin
        total++;
        bad++;
        $display("FAIL u3_unexpected_done: got DONE=1, expected no pending result (t=%0t)", $time);
      end else begin
        check("u3_result", 32'({cout3, sum3}), 32'(sb3.pop_front()));
      end
    end
  end

  // Reference: plain integer addition split into carry-out and modulo sum
  function automatic logic [8:0] ref8(input int a, input int b, input int c);
    int t;
    t = a + b + c;
    return {1'(t / 256), 8'(t % 256)};
  endfunction

  // One 8-bit transaction; glitch_at/rst_at inject START or RST in that RUN cycle
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input int glitch_at, input int rst_at);
    int  k, busy_cnt, done_k, late_done;
    bit  seen, aborted;
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    if (rst_at == 0) sb8.push_back(ref8(int'(a), int'(b), int'(c)));
    @(posedge clk);
    #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    k = 0; busy_cnt = 0; done_k = 0; seen = 0; aborted = 0;
    while (!seen && !aborted && k < 20) begin
      k++;
      @(negedge clk);
      if (done8) begin
        seen = 1;
        done_k = k;
      end else begin
        if (busy8) busy_cnt++;
        if (k == glitch_at) begin
          start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        end
        if (k == rst_at) rst8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        rst8 = 1'b0;
        if (k == rst_at) aborted = 1;
      end
    end
    if (aborted) begin
      @(negedge clk);
      check("rst_busy", 32'(busy8), 32'd0);
      check("rst_done", 32'(done8), 32'd0);
      check("rst_sum",  32'(sum8),  32'd0);
      check("rst_cout", 32'(cout8), 32'd0);
      late_done = 0;
      repeat (12) begin
        @(negedge clk);
        if (done8) late_done++;
      end
      check("rst_no_done", 32'(late_done), 32'd0);
    end else begin
      check("u8_done_seen",  32'(seen), 32'd1);
      check("u8_done_cycle", 32'(done_k), 32'd9);
      check("u8_busy_cycles", 32'(busy_cnt), 32'd8);
      @(negedge clk);
      check("u8_done_pulse", 32'(done8), 32'd0);
      check("u8_idle_busy",  32'(busy8), 32'd0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_c;
    rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    rst3 = 1'b1; start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // START during reset must lose to RST
    start8 = 1'b1; a8 = 8'h55; b8 = 8'h55;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    rst8 = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    check("reset_busy8", 32'(busy8), 32'd0);
    check("reset_done8", 32'(done8), 32'd0);
    check("reset_sum8",  32'(sum8),  32'd0);
    check("reset_cout8", 32'(cout8), 32'd0);
    check("reset_busy3", 32'(busy3), 32'd0);
    check("reset_sum3",  32'(sum3),  32'd0);

    run8(8'h00, 8'h00, 1'b0, 0, 0);
    run8(8'hFF, 8'h01, 1'b0, 0, 0);
    run8(8'h5A, 8'hA5, 1'b1, 0, 0);
    run8(8'h12, 8'h34, 1'b0, 0, 0);
    run8(8'h03, 8'h04, 1'b0, 3, 0);
    run8(8'h77, 8'h11, 1'b1, 0, 4);
    run8(8'h10, 8'h20, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++)
      run8(8'($urandom), 8'($urandom), 1'($urandom), 0, 0);

    // Exhaustive 3-bit sweep with START held high: accepts every 5 edges
    @(negedge clk);
    start3 = 1'b1;
    for (int idx = 0; idx < 128; idx++) begin
      a3 = 3'(idx); b3 = 3'(idx >> 3); cin3 = 1'(idx >> 6);
      sb3.push_back(4'((idx & 7) + ((idx >> 3) & 7) + (idx >> 6)));
      @(posedge clk);
      busy_c = 0;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        if (k < 4 && busy3) busy_c++;
        if (k == 4) check("u3_done_time", 32'(done3), 32'd1);
      end
      check("u3_busy_cycles", 32'(busy_c), 32'd3);
      @(posedge clk);
      #1;
    end
    start3 = 1'b0;

    repeat (4) @(negedge clk);
    check("sb8_drained", 32'(sb8.size()), 32'd0);
    check("sb3_drained", 32'(sb3.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_serial_adder.md
# bit_serial_adder

Sequential, LSB-first adder that adds two WIDTH-bit operands over WIDTH clock cycles using a single instance of the team's `fullAdder` cell. A carry flip-flop feeds the cell's carry-out back to its carry-in. Operand shift registers feed the cell, and a result shift register collects its sum bits. It is the area-minimal alternative to a ripple chain of `fullAdder` cells and is started and observed through a simple START/BUSY/DONE handshake.

## Interface
- WIDTH, default 8: operand and result width in bits; legal range is WIDTH >= 1.
- CLK  input  1  rising-edge clock; all state changes on this edge.
- RST  input  1  synchronous, active-high reset; sampled on CLK.
- START  input  1  request to begin an addition; sampled only in IDLE.
- A  input  WIDTH  operand A; captured on the accepting edge.
- B  input  WIDTH  operand B; captured on the accepting edge.
- CIN  input  1  initial carry-in; captured on the accepting edge.
- BUSY  output  1  high while in RUN.
- DONE  output  1  one-cycle pulse; SUM and COUT are valid while it is high.
- SUM  output  WIDTH  result, equal to (A+B+CIN) mod 2^WIDTH.
- COUT  output  1  carry-out, equal to bit WIDTH of A+B+CIN.

## Operation
- State machine has three states, IDLE, RUN and DONE, all registered.
- **IDLE**
  - START=1 loads A and B into the operand shift registers and loads CIN into the carry flop.
  - The same edge clears the bit counter and moves the machine to RUN.
  - START=0 keeps the machine in IDLE.
- **RUN** (one bit per edge)
  - The `fullAdder` instance adds the operand-register LSBs and the carry flop.
  - Its sum bit shifts into the MSB of the result register, which shifts right.
  - Its carry-out loads the carry flop.
  - Both operand registers shift right.
  - The counter increments.
  - On the edge that processes bit WIDTH-1, the machine moves to DONE.
- **DONE**
  - DONE=1, and SUM shows the full result.
  - COUT shows the carry flop, which holds the final carry.
  - The next edge moves the machine to IDLE unconditionally.
- START is ignored in RUN and DONE; no queuing, no error flag.
- A, B and CIN are don't-care outside the accepting edge.
- SUM and COUT hold their values after DONE until the next accepted START.
- During RUN, SUM shows partial shift contents and must not be used.
- COUT mirrors the carry flop and is meaningful only when DONE=1 or afterwards in IDLE.
- Counter width is clog2(WIDTH+1). WIDTH=1 gives exactly one RUN cycle.
- All arithmetic is unsigned modulo 2^WIDTH. An overflow shows up only on COUT.

## Timing
- **Reset**
  - RST=1 at an edge forces IDLE: BUSY=0, DONE=0, SUM=0, COUT=0.
  - It also clears the operand registers, the counter and the carry flop.
  - RST has priority over START.
  - Reset in RUN or DONE aborts the operation; no DONE is produced.
- **Start:** START sampled high in IDLE at edge E0 gives BUSY=1 from E0 until edge E0+WIDTH.
- **Completion:** DONE=1 in the cycle after edge E0+WIDTH, and DONE returns to 0 at edge E0+WIDTH+1.
- **Latency:** WIDTH+1 edges from the accepting edge to DONE falling.
- **Throughput:** one addition per WIDTH+2 cycles.
- **START held high:** it is accepted again at edge E0+WIDTH+2, the first IDLE edge.
- **START in the DONE cycle:** ignored.

## Test plan
- **Zero operands:** WIDTH=8, A=0x00, B=0x00, CIN=0, START for one cycle.
  - BUSY is high for exactly 8 cycles.
  - DONE then pulses once with SUM=0x00, COUT=0.
- **Wrap-around:** A=0xFF, B=0x01, CIN=0 gives SUM=0x00, COUT=1.
- **Full carry ripple with CIN:** A=0x5A, B=0xA5, CIN=1 gives SUM=0x00, COUT=1. A=0x12, B=0x34, CIN=0 gives SUM=0x46, COUT=0.
- **START while busy:** start A=0x03, B=0x04. Pulse START with A=0xFF, B=0xFF during RUN cycle 3.
  - The result is SUM=0x07, COUT=0.
  - DONE fires exactly once, at the original time.
- **Reset mid-RUN:** assert RST for one edge at RUN cycle 4.
  - Next cycle: BUSY=0, DONE=0, SUM=0, COUT=0, and no DONE pulse follows.
  - A following START with A=0x10, B=0x20 gives SUM=0x30.
- **Back-to-back, exhaustive:** hold START high with WIDTH=3 and step through all 128 (A, B, CIN) combinations.
  - Each accept is 5 cycles after the previous one.
  - Every result matches A+B+CIN, split across SUM and COUT.
